// File: rtl/y86_dmem_ctrl.sv
// Y86-64 data-memory stage: icode decode, address select,
// multi-cycle byte-addressed little-endian access with range check.
module y86_dmem_ctrl #(
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1,
  parameter int DBG_AW  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [3:0]        icode,
  input  logic [DATA_W-1:0] valA,
  input  logic [DATA_W-1:0] valE,
  input  logic [DATA_W-1:0] valP,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] valM,
  output logic              dmem_error,
  input  logic [DBG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int NB = DATA_W / 8;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [DATA_W-1:0] LIM = DATA_W'(DEPTH - NB);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  typedef struct packed {
    logic              rd;
    logic              wr;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  state_t            state;
  state_t            state_n;
  cmd_t              dec;
  cmd_t              cmd;
  logic [CW-1:0]     cnt;
  logic              accept;
  logic              complete;
  logic              in_range;
  logic [DATA_W-1:0] rdata;
  logic [7:0]        mem [DEPTH];

  // Decode icode into access kind, address and store data
  always_comb begin
    dec       = '0;
    dec.addr  = valE;
    dec.wdata = valA;
    unique case (1'b1)
      (icode == 4'h4),
      (icode == 4'hA): dec.wr = 1'b1;
      (icode == 4'h8): begin
        dec.wr    = 1'b1;
        dec.wdata = valP;
      end
      (icode == 4'h5): dec.rd = 1'b1;
      (icode == 4'h9),
      (icode == 4'hB): begin
        dec.rd   = 1'b1;
        dec.addr = valA;
      end
      default: ;
    endcase
  end

  // Next state: accept in IDLE, finish when counter drains
  always_comb begin
    state_n  = state;
    accept   = 1'b0;
    complete = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          accept  = 1'b1;
          state_n = BUSY;
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          complete = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  assign busy     = (state == BUSY);
  assign in_range = (cmd.addr <= LIM);

  // Little-endian gather at the latched address
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NB; i++) begin
      rdata[8*i +: 8] = mem[cmd.addr[AW-1:0] + AW'(i)];
    end
  end

  // Command latch, latency counter and completion outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd        <= '0;
      cnt        <= '0;
      done       <= 1'b0;
      dmem_error <= 1'b0;
      valM       <= '0;
    end else begin
      done       <= complete;
      dmem_error <= complete && (cmd.rd || cmd.wr) && !in_range;
      if (accept) begin
        cmd <= dec;
        cnt <= CW'(LATENCY - 1);
      end else if (busy && (cnt != '0)) begin
        cnt <= cnt - CW'(1);
      end
      if (complete && cmd.rd) begin
        valM <= in_range ? rdata : '0;
      end
    end
  end

  // Byte array; never reset, written only by an in-range store
  always_ff @(posedge clk) begin
    if (complete && cmd.wr && in_range) begin
      for (int i = 0; i < NB; i++) begin
        mem[cmd.addr[AW-1:0] + AW'(i)] <= cmd.wdata[8*i +: 8];
      end
    end
  end

  // Debug peek; bytes past the array read as zero
  always_comb begin
    dbg_data = '0;
    for (int i = 0; i < NB; i++) begin
      if (32'(dbg_addr) + 32'(i) < 32'(DEPTH)) begin
        dbg_data[8*i +: 8] = mem[AW'(32'(dbg_addr) + 32'(i))];
      end
    end
  end

endmodule

// File: tb/tb_y86_dmem_ctrl.sv
// Bench for y86_dmem_ctrl: directed cases plus random ops
// against a byte-array reference model.
module tb_y86_dmem_ctrl;

  localparam int DW    = 64;
  localparam int DEPTH = 1024;
  localparam int LAT   = 3;
  localparam int DBGW  = 10;
  localparam int NB    = DW / 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req = 1'b0;
  logic [3:0]      icode = '0;
  logic [DW-1:0]   valA = '0;
  logic [DW-1:0]   valE = '0;
  logic [DW-1:0]   valP = '0;
  logic            busy;
  logic            done;
  logic [DW-1:0]   valM;
  logic            dmem_error;
  logic [DBGW-1:0] dbg_addr = '0;
  logic [DW-1:0]   dbg_data;

  y86_dmem_ctrl #(
    .DATA_W(DW), .DEPTH(DEPTH), .LATENCY(LAT), .DBG_AW(DBGW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .icode(icode),
    .valA(valA), .valE(valE), .valP(valP),
    .busy(busy), .done(done), .valM(valM),
    .dmem_error(dmem_error),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] ref_mem [DEPTH];
  logic [63:0] ref_valM = '0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] peek(input logic [63:0] a);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < NB; i++) begin
      if (a + 64'(i) < 64'(DEPTH)) r[8*i +: 8] = ref_mem[int'(a) + i];
    end
    return r;
  endfunction

  task automatic dbg_chk(input logic [DBGW-1:0] a);
    dbg_addr = a;
    #1;
    check("dbg_data", dbg_data, peek(64'(a)));
  endtask

  // Issue one request from a negedge; ends at the done negedge.
  task automatic do_op(input logic [3:0] ic, input logic [63:0] a,
                       input logic [63:0] e, input logic [63:0] p);
    logic rd, wr, ok;
    logic [63:0] ad, wd;
    rd = (ic == 4'h5) || (ic == 4'h9) || (ic == 4'hB);
    wr = (ic == 4'h4) || (ic == 4'h8) || (ic == 4'hA);
    ad = ((ic == 4'h9) || (ic == 4'hB)) ? a : e;
    wd = (ic == 4'h8) ? p : a;
    ok = (ad <= 64'(DEPTH - NB));
    req = 1'b1; icode = ic; valA = a; valE = e; valP = p;
    @(posedge clk);
    for (int j = 1; j <= LAT; j++) begin
      @(negedge clk);
      check("busy_inflight", 64'(busy), 64'(1));
      check("done_early", 64'(done), 64'(0));
      req   = 1'($urandom_range(0, 1));
      icode = 4'h4;
      valA  = {$urandom, $urandom};
      valE  = 64'($urandom_range(0, DEPTH - NB));
      valP  = {$urandom, $urandom};
    end
    @(negedge clk);
    req = 1'b0;
    if (wr && ok)
      for (int i = 0; i < NB; i++) ref_mem[int'(ad) + i] = wd[8*i +: 8];
    if (rd) ref_valM = ok ? peek(ad) : 64'(0);
    check("done", 64'(done), 64'(1));
    check("busy_end", 64'(busy), 64'(0));
    check("dmem_error", 64'(dmem_error), 64'(!ok && (rd || wr)));
    check("valM", valM, ref_valM);
  endtask

  initial begin
    logic [63:0] prev, ad, dat;
    logic [3:0]  ic;
    int          sel;

    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_valM", valM, 64'(0));
    check("rst_err", 64'(dmem_error), 64'(0));
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_busy", 64'(busy), 64'(0));
      check("idle_done", 64'(done), 64'(0));
    end

    for (int w = 0; w < DEPTH / NB; w++)
      do_op(4'h4, {$urandom, $urandom}, 64'(w * NB), 64'(0));

    do_op(4'h4, 64'h0, 64'h18, 64'h0);
    do_op(4'h4, 64'h1122334455667788, 64'h10, 64'h0);
    do_op(4'h5, 64'h0, 64'h10, 64'h0);
    check("ld_value", valM, 64'h1122334455667788);
    dbg_chk(10'h10);
    check("dbg_10", dbg_data, 64'h1122334455667788);
    dbg_chk(10'h11);
    check("dbg_11", dbg_data, 64'h0011223344556677);

    do_op(4'h8, 64'h0, 64'h3F8, 64'h2A);
    do_op(4'h9, 64'h3F8, 64'h0, 64'h0);
    check("ret_value", valM, 64'h2A);

    do_op(4'h4, 64'hDEADBEEFCAFEF00D, 64'h3F9, 64'h0);
    dbg_chk(10'h3F8);
    dbg_chk(10'h3FD);
    do_op(4'h5, 64'h0, 64'hFFFFFFFFFFFFFFFC, 64'h0);
    check("oob_valM", valM, 64'h0);
    do_op(4'h5, 64'h0, 64'h3F8, 64'h0);

    prev  = ref_valM;
    req   = 1'b1;
    icode = 4'h1;
    for (int j = 0; j < 3 * (LAT + 1); j++) begin
      @(negedge clk);
      check("hs_done", 64'(done), 64'((j % (LAT + 1)) == LAT));
      check("hs_busy", 64'(busy), 64'((j % (LAT + 1)) != LAT));
      check("hs_valM", valM, prev);
    end
    req = 1'b0;
    @(negedge clk);
    check("hs_quiet", 64'(busy), 64'(0));

    req = 1'b1; icode = 4'hA; valE = 64'h20; valA = {$urandom, $urandom};
    @(posedge clk);
    @(negedge clk);
    req   = 1'b0;
    rst_n = 1'b0;
    repeat (LAT + 1) begin
      @(negedge clk);
      check("abort_done", 64'(done), 64'(0));
      check("abort_busy", 64'(busy), 64'(0));
    end
    rst_n    = 1'b1;
    ref_valM = '0;
    @(negedge clk);
    check("abort_valM", valM, 64'(0));
    check("abort_done2", 64'(done), 64'(0));
    dbg_chk(10'h20);

    for (int n = 0; n < 200; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7) ad = 64'($urandom_range(0, DEPTH - NB));
      else if (sel < 9) ad = 64'($urandom_range(DEPTH - 14, DEPTH + 6));
      else ad = {$urandom, $urandom};
      dat = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: ic = 4'h4;
        1: ic = 4'h5;
        2: ic = 4'h8;
        3: ic = 4'h9;
        4: ic = 4'hA;
        5: ic = 4'hB;
        default: ic = 4'($urandom_range(0, 15));
      endcase
      if ((ic == 4'h9) || (ic == 4'hB))
        do_op(ic, ad, dat, {$urandom, $urandom});
      else
        do_op(ic, dat, ad, {$urandom, $urandom});
      if ((n % 8) == 0) dbg_chk(DBGW'($urandom_range(0, DEPTH - 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
